// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and the
// default bit period used by both the receiver and the future transmitter.
package uart_pkg;

    localparam int UART_DATA_BITS      = 8;
    localparam int UART_CLOCKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    function automatic logic majority3(input logic [2:0] b);
        return (b[0] & b[1]) | (b[0] & b[2]) | (b[1] & b[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the rx pin followed by a 3-sample history
// whose majority gives a glitch-tolerant bit value.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rx_i,
    output logic rx_s_o,
    output logic vote_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [2:0]             hist_q;

    // Everything resets to the idle line level so no false start is seen.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
            hist_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            hist_q <= {hist_q[1:0], sync_q[SYNC_STAGES-1]};
        end
    end

    assign rx_s_o = sync_q[SYNC_STAGES-1];
    assign vote_o = majority3(hist_q);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 LSB-first UART receive front end: start qualification, mid-bit majority
// sampling, stop-bit check, one-cycle recv_ok / frame_error strobes.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = UART_CLOCKS_PER_BIT,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] recv_data,
    output logic                      recv_ok,
    output logic                      frame_error,
    output logic                      busy
);

    localparam int                CNT_W   = $clog2(CLOCKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_IDX = 3'(UART_DATA_BITS - 1);

    logic rx_s;
    logic vote;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (clk),
        .rst_ni(reset),
        .rx_i  (rx),
        .rx_s_o(rx_s),
        .vote_o(vote)
    );

    rx_state_e                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q,   cnt_d;
    logic [2:0]                idx_q,   idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] data_q,  data_d;
    logic                      ok_q,    ok_d;
    logic                      fe_q,    fe_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            ok_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            ok_q    <= ok_d;
            fe_q    <= fe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        ok_d    = 1'b0;
        fe_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A start that is no longer low at mid-bit was a glitch.
                    state_d = vote ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {vote, shift_q[UART_DATA_BITS-1:1]};
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (vote) begin
                        data_d  = shift_q;
                        ok_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK: begin
                // Hold off until the line returns high so a break is one error.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign recv_data   = data_q;
    assign recv_ok     = ok_q;
    assign frame_error = fe_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are driven onto rx, the expected
// outcome of each frame is queued, and a monitor checks every output strobe.
module tb_uart_receiver;

    localparam int CPB  = 16;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 1 + CPB / 2 + 9 * CPB;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] recv_data;
    logic       recv_ok;
    logic       frame_error;
    logic       busy;

    uart_receiver #(
        .CLOCKS_PER_BIT(CPB),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .recv_data  (recv_data),
        .recv_ok    (recv_ok),
        .frame_error(frame_error),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         is_fe;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_last;
    int         vectors;
    int         miscompares;
    int         cyc;
    int         start_cyc;
    int         last_ok_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Reference: a good stop bit yields the byte; a bad one yields an error
    // with recv_data still showing the last good byte.
    task automatic expect_frame(input logic [7:0] b, input bit stop_ok);
        exp_t e;
        if (stop_ok) begin
            e.is_fe    = 1'b0;
            e.data     = b;
            model_last = b;
        end else begin
            e.is_fe = 1'b1;
            e.data  = model_last;
        end
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int glitch_bit);
        logic v;
        expect_frame(b, stop_ok);
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            v  = (i == 0) ? 1'b0 : (i == 9) ? stop_ok : b[i-1];
            rx = v;
            if (i >= 1 && i <= 8 && (i - 1) == glitch_bit) begin
                repeat (CPB / 2) @(negedge clk);
                rx = ~v;
                @(negedge clk);
                rx = v;
                repeat (CPB / 2 - 1) @(negedge clk);
            end else begin
                repeat (CPB) @(negedge clk);
            end
        end
        rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
        chk(name, exp_q.size(), 0);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (recv_ok && frame_error) chk("strobe_overlap", 1, 0);
                if (recv_ok || frame_error) begin
                    if (recv_ok) last_ok_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_strobe", {30'd0, recv_ok, frame_error}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("strobe_kind", {31'd0, frame_error}, {31'd0, e.is_fe});
                        chk("recv_data", {24'd0, recv_data}, {24'd0, e.data});
                    end
                end
            end
        end
    end

    initial begin
        int lat;
        logic [7:0] b;
        bit         ok;
        int         gap;
        bit         prev_bad;

        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        model_last  = 8'h00;
        reset       = 1'b0;
        rx          = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_recv_data", {24'd0, recv_data}, 0);
        chk("rst_recv_ok", {31'd0, recv_ok}, 0);
        chk("rst_frame_error", {31'd0, frame_error}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        reset = 1'b1;
        idle_bits(2);

        // 1: single good byte plus latency from start edge to recv_ok
        send_frame(8'hA5, 1'b1, -1);
        idle_bits(1);
        drain("t1_drain");
        lat = last_ok_cyc - start_cyc;
        vectors++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
            miscompares++;
            $display("FAIL t1_latency: got %0d cycles, expected %0d +/-1", lat, LAT);
        end
        chk("t1_busy_after", {31'd0, busy}, 0);

        // 2: back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'h55, 1'b1, -1);
        idle_bits(1);
        drain("t2_drain");

        // 3: short low pulse is rejected as a false start
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        idle_bits(2);
        chk("t3_busy", {31'd0, busy}, 0);
        chk("t3_recv_data", {24'd0, recv_data}, {24'd0, model_last});

        // 4: bad stop bit followed by a long break, then recovery
        send_frame(8'h3C, 1'b0, -1);
        rx = 1'b0;
        repeat (40 * CPB) @(negedge clk);
        chk("t4_busy_in_break", {31'd0, busy}, 1);
        chk("t4_recv_data_kept", {24'd0, recv_data}, 8'h55);
        idle_bits(2);
        chk("t4_busy_after_break", {31'd0, busy}, 0);
        send_frame(8'h81, 1'b1, -1);
        idle_bits(1);
        drain("t4_drain");

        // 5: one-cycle glitch at a data-bit midpoint is voted out
        send_frame(8'h0F, 1'b1, 2);
        send_frame(8'h0F, 1'b1, 5);
        idle_bits(1);
        drain("t5_drain");

        // 6: reset in the middle of bit 4 aborts the frame
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        b = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = b[4];
        repeat (CPB / 2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6_rst_recv_data", {24'd0, recv_data}, 0);
        chk("t6_rst_busy", {31'd0, busy}, 0);
        chk("t6_rst_recv_ok", {31'd0, recv_ok}, 0);
        rx = 1'b1;
        model_last = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle_bits(2);
        chk("t6_recv_data_idle", {24'd0, recv_data}, 0);
        send_frame(8'h12, 1'b1, -1);
        idle_bits(1);
        drain("t6_drain");

        // Random traffic; a bad stop bit is always followed by idle line
        prev_bad = 1'b0;
        for (int n = 0; n < 30; n++) begin
            b   = 8'($urandom);
            ok  = ($urandom_range(0, 5) != 0);
            gap = $urandom_range(0, 2);
            if (prev_bad && gap == 0) gap = 1;
            if (gap != 0) idle_bits(gap);
            send_frame(b, ok, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
            prev_bad = !ok;
        end
        idle_bits(2);
        drain("rand_drain");
        chk("final_busy", {31'd0, busy}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receive front end (8N1, LSB first) that sits directly upstream of the UART controller's receive FIFO. It synchronises the asynchronous rx pin, detects and qualifies start bits, samples each bit at mid-period with a 3-sample majority vote, and checks the stop bit. Each good byte is delivered as recv_data plus a one-cycle recv_ok strobe, which is the exact format the controller consumes. Stop-bit violations are reported on frame_error instead of producing a byte.

Parameters:
CLOCKS_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200); legal range >= 8.
SYNC_STAGES, 2, flip-flop depth of the rx input synchroniser; legal range >= 2.

Ports:
clk  input  1  system clock; all state on posedge.
reset  input  1  asynchronous, active-low reset (asserted when 0); the controller's recv_reset drives it through an inverter at top level.
rx  input  1  asynchronous serial line; idle level 1.
recv_data  output  8  last correctly received byte.
recv_ok  output  1  one-cycle strobe: recv_data valid and new.
frame_error  output  1  one-cycle strobe: stop bit sampled as 0.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset values (reset == 0): state IDLE, all synchroniser flops 1, vote history 3'b111, counters 0, shift register 0, recv_data 8'h00, recv_ok 0, frame_error 0, busy 0.
- Reset mid-frame: all of the above apply immediately (asynchronously). The partial byte is discarded and no strobe is issued.
- Synchroniser: SYNC_STAGES flops give rx_s. A 3-bit history of rx_s is kept. vote = majority of the 3 history bits.
- Bit counter width: $clog2(CLOCKS_PER_BIT). HALF = CLOCKS_PER_BIT/2 (integer division). Bit index is 3 bits.
- State machine:
  - IDLE: when rx_s == 0 → START, cnt = 0.
  - START: cnt increments each cycle. At cnt == HALF-1:
    - vote == 0 → DATA, cnt = 0, idx = 0.
    - otherwise → IDLE (false start; glitch rejected, no strobe).
  - DATA: cnt increments. At cnt == CLOCKS_PER_BIT-1:
    - shift = {vote, shift[7:1]} (LSB first), cnt = 0.
    - If idx == 7 → STOP; else idx = idx+1.
  - STOP: at cnt == CLOCKS_PER_BIT-1:
    - vote == 1 → recv_data = shift, recv_ok = 1 for exactly one cycle, → IDLE.
    - vote == 0 → frame_error = 1 for exactly one cycle, recv_data unchanged, → BREAK.
  - BREAK: wait until rx_s == 1, then → IDLE. A held-low line (break) therefore produces exactly one frame_error and no spurious start.
- recv_ok and frame_error are never high in the same cycle. Both are registered outputs.
- recv_data holds its value until the next good byte; there is no back-pressure.
- Back-to-back frames: a start bit beginning immediately after the stop-bit sample point is detected. IDLE is re-entered at mid-stop-bit, leaving half a bit of margin.
- Latency: recv_ok rises SYNC_STAGES + 1 + HALF + 9*CLOCKS_PER_BIT cycles (±1) after the falling edge of the start bit on rx.
- Counters wrap only by explicit clear; no free-running overflow.

Decomposition:
- Package uart_pkg:
  - typedef enum of rx states {IDLE, START, DATA, STOP, BREAK};
  - localparam UART_DATA_BITS = 8;
  - default CLOCKS_PER_BIT constant, shared with the future transmitter.
- Sub-module uart_rx_sync: SYNC_STAGES synchroniser plus 3-bit majority vote. Outputs rx_s and vote. Async active-low reset to all-ones.

Test Plan (CLOCKS_PER_BIT = 16, SYNC_STAGES = 2):
1. Send 8'hA5 with a valid stop bit → one recv_ok pulse, recv_data == 8'hA5, frame_error stays 0, busy low afterwards.
2. Send 8'h00, 8'hFF, 8'h55 back-to-back with no idle gap → three recv_ok pulses with the correct data in order.
3. rx low pulse of 5 cycles, then high → no recv_ok, no frame_error, state returns to IDLE.
4. Send 8'h3C with stop bit = 0, then hold rx low for 40 bit times → exactly one frame_error pulse, recv_data keeps its prior value. After rx rises, 8'h81 is received correctly.
5. Single 1-cycle inverted glitch at a data-bit mid-point while sending 8'h0F → majority vote recovers, recv_data == 8'h0F.
6. Assert reset during bit 4 of 8'hC3, release, then send 8'h12 → no strobe for the aborted frame, outputs at reset values, then recv_data == 8'h12 with one recv_ok.
